// File: rtl/pattern_scan_ctrl.sv
// Frame-based serial pattern scanner: latches a pattern and a frame length on
// start, scans that many valid bits with overlapping matches, reports a count.
module pattern_scan_ctrl #(
   parameter int PAT_W = 5,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] frame_len,
   input  logic             bit_valid,
   input  logic             d_in,
   output logic             busy,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             done
);

   localparam int HIST_W = PAT_W - 1;
   localparam int FILL_W = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(HIST_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic [HIST_W-1:0]  hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;

   logic               accept;
   logic               last_bit;
   logic               hit;
   logic [PAT_W-1:0]   window;

   assign accept   = (state_q == S_RUN) && bit_valid;
   assign window   = {hist_q, d_in};
   // bit_cnt_q holds bits already taken, so the current bit is number bit_cnt_q+1
   assign last_bit = (bit_cnt_q == (len_q - CNT_W'(1)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (len_q == '0) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (accept && last_bit) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      busy = (state_q == S_LOAD) || (state_q == S_RUN);
      done = (state_q == S_DONE);
      hit  = accept && (fill_q == FILL_FULL) && (window == pat_q);
      match = hit;
   end

   always_comb begin
      pat_d       = pat_q;
      len_d       = len_q;
      hist_d      = hist_q;
      fill_d      = fill_q;
      bit_cnt_d   = bit_cnt_q;
      match_cnt_d = match_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               pat_d = pattern;
               len_d = frame_len;
            end
         end
         S_LOAD: begin
            hist_d      = '0;
            fill_d      = '0;
            bit_cnt_d   = '0;
            match_cnt_d = '0;
         end
         S_RUN: begin
            if (bit_valid) begin
               hist_d    = window[HIST_W-1:0];
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (fill_q != FILL_FULL) begin
                  fill_d = fill_q + FILL_W'(1);
               end
               // history is kept after a hit so overlapping matches count
               if (hit && !(&match_cnt_q)) begin
                  match_cnt_d = match_cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_q       <= '0;
         len_q       <= '0;
         hist_q      <= '0;
         fill_q      <= '0;
         bit_cnt_q   <= '0;
         match_cnt_q <= '0;
      end else begin
         pat_q       <= pat_d;
         len_q       <= len_d;
         hist_q      <= hist_d;
         fill_q      <= fill_d;
         bit_cnt_q   <= bit_cnt_d;
         match_cnt_q <= match_cnt_d;
      end
   end

   assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: vector table, directed corner sequences and
// random scans against a bit-list reference model.
module tb_pattern_scan_ctrl;

   localparam int PAT_W = 5;
   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   localparam int M_IDLE = 0;
   localparam int M_LOAD = 1;
   localparam int M_RUN  = 2;
   localparam int M_DONE = 3;

   typedef struct {
      logic             st;
      logic             ab;
      logic [PAT_W-1:0] pat;
      logic [CNT_W-1:0] len;
      logic             bv;
      logic             d;
      logic             eb;
      logic             em;
      logic [CNT_W-1:0] ec;
      logic             ed;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [PAT_W-1:0] pattern = '0;
   logic [CNT_W-1:0] frame_len = '0;
   logic             bit_valid = 1'b0;
   logic             d_in = 1'b0;
   logic             busy;
   logic             match;
   logic [CNT_W-1:0] match_cnt;
   logic             done;

   int vectors = 0;
   int miscompares = 0;
   int done_seen = 0;

   int m_ph;
   int m_pat;
   int m_len;
   int m_cnt;
   bit mq[$];

   vec_t tbl[$];

   pattern_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .abort(abort),
      .pattern(pattern),
      .frame_len(frame_len),
      .bit_valid(bit_valid),
      .d_in(d_in),
      .busy(busy),
      .match(match),
      .match_cnt(match_cnt),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void m_reset();
      m_ph  = M_IDLE;
      m_cnt = 0;
      mq.delete();
   endfunction

   // a match is the last PAT_W accepted bits of this frame read as a number
   function automatic bit m_hit(input bit bv, input bit d);
      int v;
      v = 0;
      if (m_ph != M_RUN || !bv || mq.size() < PAT_W - 1) return 1'b0;
      for (int i = mq.size() - (PAT_W - 1); i < mq.size(); i++) v = v * 2 + int'(mq[i]);
      v = v * 2 + int'(d);
      return v == m_pat;
   endfunction

   task automatic m_step(input vec_t v);
      bit h;
      h = m_hit(v.bv, v.d);
      case (m_ph)
         M_IDLE: begin
            if (v.st) begin
               m_pat = int'(v.pat);
               m_len = int'(v.len);
               m_ph  = M_LOAD;
            end
         end
         M_LOAD: begin
            mq.delete();
            m_cnt = 0;
            if (v.ab) m_ph = M_IDLE;
            else if (m_len == 0) m_ph = M_DONE;
            else m_ph = M_RUN;
         end
         M_RUN: begin
            if (v.bv) begin
               if (h && m_cnt < CMAX) m_cnt++;
               mq.push_back(v.d);
            end
            if (v.ab) m_ph = M_IDLE;
            else if (v.bv && mq.size() == m_len) m_ph = M_DONE;
         end
         default: m_ph = M_IDLE;
      endcase
   endtask

   // entered and left at posedge+1; outputs sampled at the falling edge
   task automatic cyc(input vec_t v, input bit use_tbl);
      start     = v.st;
      abort     = v.ab;
      pattern   = v.pat;
      frame_len = v.len;
      bit_valid = v.bv;
      d_in      = v.d;
      #4;
      chk("busy", int'(busy), int'(m_ph == M_LOAD || m_ph == M_RUN));
      chk("match", int'(match), int'(m_hit(v.bv, v.d)));
      chk("match_cnt", int'(match_cnt), m_cnt);
      chk("done", int'(done), int'(m_ph == M_DONE));
      if (use_tbl) begin
         chk("tbl_busy", int'(busy), int'(v.eb));
         chk("tbl_match", int'(match), int'(v.em));
         chk("tbl_cnt", int'(match_cnt), int'(v.ec));
         chk("tbl_done", int'(done), int'(v.ed));
      end
      if (done === 1'b1) done_seen++;
      @(posedge clk);
      m_step(v);
      #1;
   endtask

   function automatic vec_t mk(input logic st, input logic ab,
                               input logic [PAT_W-1:0] pat,
                               input logic [CNT_W-1:0] len,
                               input logic bv, input logic d);
      vec_t v;
      v.st = st; v.ab = ab; v.pat = pat; v.len = len; v.bv = bv; v.d = d;
      v.eb = 1'b0; v.em = 1'b0; v.ec = '0; v.ed = 1'b0;
      return v;
   endfunction

   task automatic drv(input logic st, input logic ab,
                      input logic [PAT_W-1:0] pat,
                      input logic [CNT_W-1:0] len,
                      input logic bv, input logic d);
      cyc(mk(st, ab, pat, len, bv, d), 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drv(1'b0, 1'b0, PAT_W'($urandom), CNT_W'($urandom),
             1'($urandom), 1'($urandom));
   endtask

   function automatic void add(input logic st, input logic [PAT_W-1:0] pat,
                               input logic [CNT_W-1:0] len,
                               input logic bv, input logic d,
                               input logic eb, input logic em,
                               input logic [CNT_W-1:0] ec, input logic ed);
      vec_t v;
      v = mk(st, 1'b0, pat, len, bv, d);
      v.eb = eb; v.em = em; v.ec = ec; v.ed = ed;
      tbl.push_back(v);
   endfunction

   initial begin
      logic [PAT_W-1:0] rp;
      logic [CNT_W-1:0] rl;
      logic rbv, rd;
      int k;

      // 10101 over ten alternating bits: hits on bits 5, 7, 9
      add(1, 5'b10101, 8'd10, 0, 0, 0, 0, 8'd0, 0);
      add(0, 5'b00000, 8'd0,  0, 0, 1, 0, 8'd0, 0);
      add(0, 5'b00000, 8'd0,  1, 1, 1, 0, 8'd0, 0);
      add(0, 5'b00000, 8'd0,  1, 0, 1, 0, 8'd0, 0);
      add(0, 5'b00000, 8'd0,  1, 1, 1, 0, 8'd0, 0);
      add(0, 5'b00000, 8'd0,  1, 0, 1, 0, 8'd0, 0);
      add(0, 5'b00000, 8'd0,  1, 1, 1, 1, 8'd0, 0);
      add(0, 5'b00000, 8'd0,  1, 0, 1, 0, 8'd1, 0);
      add(0, 5'b00000, 8'd0,  1, 1, 1, 1, 8'd1, 0);
      add(0, 5'b00000, 8'd0,  1, 0, 1, 0, 8'd2, 0);
      add(0, 5'b00000, 8'd0,  1, 1, 1, 1, 8'd2, 0);
      add(0, 5'b00000, 8'd0,  1, 0, 1, 0, 8'd3, 0);
      add(0, 5'b00000, 8'd0,  0, 0, 0, 0, 8'd3, 1);
      add(0, 5'b00000, 8'd0,  0, 0, 0, 0, 8'd3, 0);
      // zero-length frame: LOAD then DONE, stream ignored
      add(1, 5'b10101, 8'd0,  0, 0, 0, 0, 8'd3, 0);
      add(0, 5'b00000, 8'd0,  1, 1, 1, 0, 8'd3, 0);
      add(0, 5'b00000, 8'd0,  1, 1, 0, 0, 8'd0, 1);
      add(0, 5'b00000, 8'd0,  1, 1, 0, 0, 8'd0, 0);

      m_reset();
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_match", int'(match), 0);
      chk("rst_cnt", int'(match_cnt), 0);
      chk("rst_done", int'(done), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      foreach (tbl[i]) cyc(tbl[i], 1'b1);

      // same frame with three idle cycles of noise between bits
      done_seen = 0;
      drv(1, 0, 5'b10101, 8'd10, 0, 0);
      drv(0, 0, 5'b00000, 8'd0, 0, 0);
      for (int b = 0; b < 10; b++) begin
         drv(0, 0, PAT_W'($urandom), CNT_W'($urandom), 1, 1'(b % 2 == 0));
         for (int j = 0; j < 3; j++)
            drv(0, 0, PAT_W'($urandom), CNT_W'($urandom), 0, 1'($urandom));
      end
      chk("gap_cnt", int'(match_cnt), 3);
      chk("gap_done", done_seen, 1);

      // ones sent while idle must not prime the history
      done_seen = 0;
      for (int j = 0; j < 5; j++) drv(0, 0, 5'b11111, 8'd4, 1, 1);
      drv(1, 0, 5'b11111, 8'd4, 1, 1);
      drv(0, 0, 5'b11111, 8'd4, 1, 1);
      for (int j = 0; j < 4; j++) drv(0, 0, 5'b00000, 8'd0, 1, 1);
      idle(2);
      chk("prefill_cnt", int'(match_cnt), 0);
      chk("prefill_done", done_seen, 1);

      // abort with bit 12; start and pattern change mid-run are ignored
      done_seen = 0;
      drv(1, 0, 5'b00000, 8'd20, 0, 0);
      drv(0, 0, 5'b00000, 8'd0, 0, 0);
      for (int b = 1; b <= 11; b++) begin
         if (b == 3) drv(1, 0, 5'b11111, 8'd5, 1, 0);
         else if (b >= 6) drv(0, 0, 5'b10110, 8'd3, 1, 0);
         else drv(0, 0, 5'b00000, 8'd0, 1, 0);
      end
      drv(0, 1, 5'b00000, 8'd0, 1, 0);
      chk("abort_busy", int'(busy), 0);
      idle(2);
      chk("abort_cnt", int'(match_cnt), 8);
      chk("abort_done", done_seen, 0);

      // asynchronous reset mid-run after two matches
      done_seen = 0;
      drv(1, 0, 5'b10101, 8'd20, 0, 0);
      drv(0, 0, 5'b00000, 8'd0, 0, 0);
      for (int b = 0; b < 7; b++) drv(0, 0, 5'b00000, 8'd0, 1, 1'(b % 2 == 0));
      chk("pre_rst_cnt", int'(match_cnt), 2);
      start = 1'b0;
      abort = 1'b0;
      bit_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_cnt", int'(match_cnt), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_match", int'(match), 0);
      #2;
      rst = 1'b1;
      m_reset();
      @(posedge clk);
      #1;
      drv(1, 0, 5'b10101, 8'd10, 0, 0);
      drv(0, 0, 5'b00000, 8'd0, 0, 0);
      for (int b = 0; b < 10; b++) drv(0, 0, 5'b00000, 8'd0, 1, 1'(b % 2 == 0));
      drv(0, 0, 5'b00000, 8'd0, 0, 0);
      chk("post_rst_cnt", int'(match_cnt), 3);
      chk("post_rst_done", done_seen, 1);

      // longest frame, all zeros: 251 overlapping hits
      drv(1, 0, 5'b00000, 8'd255, 0, 0);
      for (int c = 0; c < 300 && m_ph != M_IDLE; c++)
         drv(0, 0, 5'b00000, 8'd0, 1, 0);
      chk("long_cnt", int'(match_cnt), 251);

      // random scans, stream mostly follows the pattern to create hits
      for (int s = 0; s < 40; s++) begin
         idle($urandom_range(0, 2));
         rp = PAT_W'($urandom);
         if ($urandom_range(0, 9) == 0) rl = CNT_W'($urandom_range(0, 3));
         else rl = CNT_W'($urandom_range(4, 40));
         drv(1, 0, rp, rl, 1'($urandom), 1'($urandom));
         k = 0;
         for (int c = 0; c < 1000 && m_ph != M_IDLE; c++) begin
            rbv = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 4) == 0) rd = 1'($urandom);
            else rd = rp[PAT_W - 1 - (k % PAT_W)];
            if (rbv) k++;
            drv(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 199) == 0),
                PAT_W'($urandom), CNT_W'($urandom), rbv, rd);
         end
         if (m_ph != M_IDLE) chk("scan_timeout", 0, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
